div_frac_seq: RTL and testbench

- Parametrised sequential fractional divider; successor to the fixed 32-bit fractional divide datapath in the FPU.
- Computes the fractional quotient floor(|dividend| * 2^RES_WIDTH / |divisor|) by radix-2 restoring division, one quotient bit per cycle.
- Adds over the previous generation: configurable width and result precision, runtime signed/unsigned mode, remainder output, divide-by-zero and overflow flags, and a done pulse.
- Used by FPU mantissa division and fixed-point normalisation paths.

---
 rtl/div_frac_seq_if.sv | 30 +++
 rtl/div_frac_seq.sv | 106 ++++++++++
 tb/tb_div_frac_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_frac_seq_if.sv
// div_frac_seq_if -- request/result bundle for the sequential fractional divider.
//   master: drives start, signed_mode, dividend, divisor; observes results.
//   slave : the divider; observes the request, drives busy, done, res, res_neg,
//           rem, dz, ovf.
interface div_frac_seq_if #(
    parameter int WIDTH     = 32,
    parameter int RES_WIDTH = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [RES_WIDTH-1:0] res;
    logic                 res_neg;
    logic [WIDTH-1:0]     rem;
    logic                 dz;
    logic                 ovf;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, res, res_neg, rem, dz, ovf
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, res, res_neg, rem, dz, ovf
    );
endinterface

// File: rtl/div_frac_seq.sv
// div_frac_seq -- radix-2 restoring fractional divider, one quotient bit per cycle.
// Produces res = floor(|dividend| * 2^RES_WIDTH / |divisor|) as a magnitude with a
// separate sign (res_neg), plus the final partial remainder.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of div_frac_seq_if (start/operands in, busy/done/results out)
module div_frac_seq #(
    parameter int WIDTH     = 32,
    parameter int RES_WIDTH = 32,
    parameter int CNT_W     = $clog2(RES_WIDTH + 1)
) (
    input logic          clk,
    input logic          rst,
    div_frac_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     dvs;     // latched |divisor|
    logic [WIDTH-1:0]     r;       // partial remainder, always < dvs
    logic [RES_WIDTH-1:0] q;
    logic                 neg_q, dz_q, ovf_q;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which read unsigned
    // is exactly 2^(WIDTH-1), so no extra bit is needed.
    logic             dd_neg, dv_neg, dv_zero, dd_ge;
    logic [WIDTH-1:0] dd_mag, dv_mag;

    assign dd_neg  = bus.signed_mode & bus.dividend[WIDTH-1];
    assign dv_neg  = bus.signed_mode & bus.divisor[WIDTH-1];
    assign dd_mag  = dd_neg ? (WIDTH'(0) - bus.dividend) : bus.dividend;
    assign dv_mag  = dv_neg ? (WIDTH'(0) - bus.divisor)  : bus.divisor;
    assign dv_zero = (dv_mag == '0);
    assign dd_ge   = (dd_mag >= dv_mag);

    // One restoring step. t is WIDTH+1 bits so the shifted-out MSB takes part in
    // the compare; the difference always fits in WIDTH bits when t >= dvs.
    logic [WIDTH:0]   t;
    logic             t_ge;
    logic [WIDTH-1:0] t_sub;
    logic             last_iter;

    assign t         = {r, 1'b0};
    assign t_ge      = (t >= {1'b0, dvs});
    assign t_sub     = t[WIDTH-1:0] - dvs;
    assign last_iter = (cnt == CNT_W'(RES_WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (dv_zero || dd_ge) ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            dvs   <= '0;
            r     <= '0;
            q     <= '0;
            neg_q <= 1'b0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cnt   <= '0;
                    dvs   <= dv_mag;
                    neg_q <= (dd_neg ^ dv_neg) & (|bus.dividend);
                    dz_q  <= dv_zero;
                    ovf_q <= ~dv_zero & dd_ge;
                    if (dv_zero || dd_ge) begin
                        q <= '1;
                        r <= '0;
                    end else begin
                        q <= '0;
                        r <= dd_mag;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    q   <= {q[RES_WIDTH-2:0], t_ge};
                    r   <= t_ge ? t_sub : t[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.res     = q;
    assign bus.res_neg = neg_q;
    assign bus.rem     = r;
    assign bus.dz      = dz_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_div_frac_seq.sv
// tb_div_frac_seq -- self-checking bench for div_frac_seq: a 32/32 build and an
// 8/12 build, directed cases plus randomized operands checked against an
// arithmetic reference model.
module tb_div_frac_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_frac_seq_if #(.WIDTH(32), .RES_WIDTH(32)) b32 ();
    div_frac_seq_if #(.WIDTH(8),  .RES_WIDTH(12)) b8 ();

    div_frac_seq #(.WIDTH(32), .RES_WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    div_frac_seq #(.WIDTH(8),  .RES_WIDTH(12)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: sign-magnitude fractional quotient from plain integer arithmetic.
    function automatic void model(input bit sm, input logic [31:0] dd, input logic [31:0] dv,
                                  input int w, input int rw,
                                  output logic [63:0] q, output logic [63:0] rm,
                                  output logic ng, output logic z, output logic o);
        logic [31:0]  mask, a, b, am, bm;
        logic         an, bn;
        logic [127:0] num;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a  = dd & mask;
        b  = dv & mask;
        an = sm && a[w-1];
        bn = sm && b[w-1];
        am = an ? ((~a + 32'd1) & mask) : a;
        bm = bn ? ((~b + 32'd1) & mask) : b;
        ng = (an ^ bn) && (a != 0);
        z  = (bm == 0);
        o  = !z && (am >= bm);
        if (z || o) begin
            q  = (64'd1 << rw) - 64'd1;
            rm = 64'd0;
        end else begin
            num = 128'(am) << rw;
            q   = 64'(num / 128'(bm));
            rm  = 64'(num % 128'(bm));
        end
    endfunction

    // One 32-bit divide. poke_k_in>0 re-pulses start with junk operands in that
    // cycle of the operation; it must be ignored.
    task automatic run32(input bit sm, input logic [31:0] dd, input logic [31:0] dv,
                         input int poke_k_in, input string tag);
        logic [63:0] eq, er;
        logic        en, ez, eo;
        int          exp_lat, lat, busy_n, done_n, poke_k;
        logic [31:0] g_res, g_rem;
        logic        g_neg, g_dz, g_ovf;
        model(sm, dd, dv, 32, 32, eq, er, en, ez, eo);
        exp_lat = (ez || eo) ? 1 : 33;
        poke_k  = (poke_k_in > exp_lat) ? 0 : poke_k_in;
        lat = 0; busy_n = 0; done_n = 0;
        g_res = '0; g_rem = '0; g_neg = 0; g_dz = 0; g_ovf = 0;
        @(negedge clk);
        b32.start = 1'b1; b32.signed_mode = sm; b32.dividend = dd; b32.divisor = dv;
        @(posedge clk); #1;
        b32.start = 1'b0; b32.signed_mode = ~sm;
        b32.dividend = $urandom; b32.divisor = $urandom;
        for (int k = 1; k <= exp_lat + 3; k++) begin
            @(negedge clk);
            b32.start = (k == poke_k);
            if (b32.busy) busy_n++;
            if (b32.done) begin
                done_n++;
                if (lat == 0) begin
                    lat = k;
                    g_res = b32.res; g_rem = b32.rem; g_neg = b32.res_neg;
                    g_dz = b32.dz; g_ovf = b32.ovf;
                end
            end
        end
        b32.start = 1'b0;
        chk({tag, ":lat"},   64'(lat),    64'(exp_lat));
        chk({tag, ":busy"},  64'(busy_n), 64'(exp_lat));
        chk({tag, ":ndone"}, 64'(done_n), 64'd1);
        chk({tag, ":res"},   64'(g_res),  eq);
        chk({tag, ":rem"},   64'(g_rem),  er);
        chk({tag, ":neg"},   64'(g_neg),  64'(en));
        chk({tag, ":dz"},    64'(g_dz),   64'(ez));
        chk({tag, ":ovf"},   64'(g_ovf),  64'(eo));
        chk({tag, ":hold"},  64'(b32.res), eq);
    endtask

    task automatic run8(input bit sm, input logic [7:0] dd, input logic [7:0] dv, input string tag);
        logic [63:0] eq, er;
        logic        en, ez, eo;
        int          exp_lat, lat;
        logic [11:0] g_res;
        logic [7:0]  g_rem;
        logic        g_neg, g_dz, g_ovf;
        model(sm, 32'(dd), 32'(dv), 8, 12, eq, er, en, ez, eo);
        exp_lat = (ez || eo) ? 1 : 13;
        lat = 0; g_res = '0; g_rem = '0; g_neg = 0; g_dz = 0; g_ovf = 0;
        @(negedge clk);
        b8.start = 1'b1; b8.signed_mode = sm; b8.dividend = dd; b8.divisor = dv;
        @(posedge clk); #1;
        b8.start = 1'b0;
        for (int k = 1; k <= exp_lat + 3; k++) begin
            @(negedge clk);
            if (b8.done && lat == 0) begin
                lat = k;
                g_res = b8.res; g_rem = b8.rem; g_neg = b8.res_neg;
                g_dz = b8.dz; g_ovf = b8.ovf;
            end
        end
        chk({tag, ":lat"}, 64'(lat),   64'(exp_lat));
        chk({tag, ":res"}, 64'(g_res), eq);
        chk({tag, ":rem"}, 64'(g_rem), er);
        chk({tag, ":neg"}, 64'(g_neg), 64'(en));
        chk({tag, ":dz"},  64'(g_dz),  64'(ez));
        chk({tag, ":ovf"}, 64'(g_ovf), 64'(eo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dd, dv;
        logic [7:0]  d8, v8;
        bit          sm;
        int          dk[3];
        int          nd;

        rst = 1'b0;
        b32.start = 0; b32.signed_mode = 0; b32.dividend = '0; b32.divisor = '0;
        b8.start  = 0; b8.signed_mode  = 0; b8.dividend  = '0; b8.divisor  = '0;
        #2;
        chk("rst:busy", 64'(b32.busy),    64'd0);
        chk("rst:done", 64'(b32.done),    64'd0);
        chk("rst:res",  64'(b32.res),     64'd0);
        chk("rst:rem",  64'(b32.rem),     64'd0);
        chk("rst:flag", 64'({b32.res_neg, b32.dz, b32.ovf}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed cases
        run32(0, 32'd1, 32'd2, 10, "u_1_2");
        run32(0, 32'd1, 32'd3, 0,  "u_1_3");
        run32(0, 32'd7, 32'd0, 1,  "dz");
        run32(0, 32'd5, 32'd5, 0,  "ovf_eq");
        run32(1, 32'hFFFF_FFFF, 32'd4, 0, "s_m1_4");
        run32(1, 32'd0, 32'hFFFF_FFFD, 0, "s_0_m3");
        run32(1, 32'h8000_0000, 32'h8000_0000, 0, "s_min_min");
        run32(1, 32'd3, 32'h8000_0000, 0, "s_3_min");
        run32(0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3, "u_max");
        run8(0, 8'd3, 8'd7, "w8_3_7");
        run8(1, 8'hFD, 8'h80, "w8_m3_min");
        run8(1, 8'h05, 8'h00, "w8_dz");

        // Randomized operands with varied magnitudes
        repeat (40) begin
            sm = 1'($urandom_range(0, 1));
            dd = $urandom >> $urandom_range(0, 31);
            dv = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (sm && $urandom_range(0, 1) == 1) dd = -dd;
            if (sm && $urandom_range(0, 1) == 1) dv = -dv;
            run32(sm, dd, dv, $urandom_range(0, 5), "rnd32");
        end
        repeat (20) begin
            sm = 1'($urandom_range(0, 1));
            d8 = 8'($urandom);
            v8 = 8'($urandom >> $urandom_range(0, 7));
            run8(sm, d8, v8, "rnd8");
        end

        // Back-to-back: start held high, one done every RES_WIDTH+2 cycles
        @(negedge clk);
        b32.start = 1'b1; b32.signed_mode = 0; b32.dividend = 32'd1; b32.divisor = 32'd3;
        nd = 0;
        for (int k = 0; k < 120 && nd < 3; k++) begin
            @(negedge clk);
            if (b32.done) begin
                dk[nd] = k;
                nd++;
                chk("b2b:res", 64'(b32.res), 64'h5555_5555);
            end
        end
        b32.start = 1'b0;
        chk("b2b:ndone", 64'(nd), 64'd3);
        chk("b2b:gap1", 64'(dk[1] - dk[0]), 64'd34);
        chk("b2b:gap2", 64'(dk[2] - dk[1]), 64'd34);
        for (int k = 0; k < 40 && b32.busy; k++) @(negedge clk);
        chk("b2b:idle", 64'(b32.busy), 64'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        b32.start = 1'b1; b32.dividend = 32'd1; b32.divisor = 32'd2;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst:busy", 64'(b32.busy), 64'd0);
        chk("mrst:done", 64'(b32.done), 64'd0);
        chk("mrst:res",  64'(b32.res),  64'd0);
        chk("mrst:rem",  64'(b32.rem),  64'd0);
        chk("mrst:flag", 64'({b32.res_neg, b32.dz, b32.ovf}), 64'd0);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (b32.done) nd++;
        end
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (b32.done) nd++;
        end
        chk("mrst:nodone", 64'(nd), 64'd0);
        run32(0, 32'd1, 32'd2, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
